// File: rtl/rgmii_tx_framer_pkg.sv
// rgmii_tx_framer_pkg: shared constants, TX FSM states and reflected CRC-32 byte step for the RGMII TX framer
package rgmii_tx_framer_pkg;
  localparam int RGMII_DATA_W = 4;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} tx_state_t;
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c, p;
    for (int i = 0; i < 32; i++) p[i] = CRC32_POLY[31-i];
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ p : c >> 1;
    return c;
  endfunction
endpackage

// File: rtl/rgmii_tx_framer_if.sv
// rgmii_if: RGMII TX pin bundle (4-bit DDR data, DDR ctrl); master drives, slave observes
interface rgmii_if;
  import rgmii_tx_framer_pkg::*;
  logic [RGMII_DATA_W-1:0] data;
  logic ctrl;
  modport master(output data, ctrl);
  modport slave(input data, ctrl);
endinterface

// File: rtl/rgmii_tx_framer_oddr_sim.sv
// oddr_sim: behavioural SAME_EDGE ODDR (d1/d2 sampled on rise, d1 shown while clk high, d2 while low) with async r
module oddr_sim (
  input  logic clk,
  input  logic r,
  input  logic d1,
  input  logic d2,
  output logic q
);
  logic q_r, q_f;
  always_ff @(posedge clk or posedge r)
    if (r) begin
      q_r <= 1'b0;
      q_f <= 1'b0;
    end else begin
      q_r <= d1;
      q_f <= d2;
    end
  assign q = clk ? q_r : q_f;
endmodule

// File: rtl/rgmii_tx_framer.sv
// rgmii_tx_framer: byte stream -> GMII frame (preamble/SFD/payload/pad/[FCS when TX_FCS_EN]/IFG) -> RGMII DDR pins via ODDR
module rgmii_tx_framer import rgmii_tx_framer_pkg::*; #(
  parameter string TARGET = "SIM",
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_PAYLOAD = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  input  logic       s_err,
  output logic       s_ready,
  output logic       busy,
  rgmii_if.master    rgmii_if_tx_o
);
`ifdef TX_FCS_EN
  localparam tx_state_t TAIL = FCS;
`else
  localparam tx_state_t TAIL = IFG;
`endif
  tx_state_t state, state_n;
  logic [7:0] cnt, cnt_n, txd;
  logic [10:0] byte_cnt, byte_cnt_n, byte_inc;
  logic [11:0] byte_nxt;
  logic tx_en, tx_er;
  logic [RGMII_DATA_W:0] d1, d2, pin_q;
  assign byte_inc = &byte_cnt ? byte_cnt : byte_cnt + 11'd1;
  assign byte_nxt = {1'b0, byte_cnt} + 12'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      byte_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      byte_cnt <= byte_cnt_n;
    end
`ifdef TX_FCS_EN
  logic [31:0] crc, fcs;
  assign fcs = ~crc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc <= CRC32_INIT;
    else if (state == SFD) crc <= CRC32_INIT;
    else if ((state == DATA && s_valid) || state == PAD) crc <= crc32_byte(crc, txd);
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt + 8'd1;
    byte_cnt_n = byte_cnt;
    s_ready = 1'b0;
    tx_en = 1'b0;
    tx_er = 1'b0;
    txd = 8'h00;
    busy = state != IDLE;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (s_valid) state_n = PREAMBLE;
      end
      PREAMBLE: begin
        tx_en = 1'b1;
        txd = PREAMBLE_BYTE;
        if (cnt == 8'(PREAMBLE_BYTES - 1)) state_n = SFD;
      end
      SFD: begin
        tx_en = 1'b1;
        txd = SFD_BYTE;
        byte_cnt_n = '0;
        state_n = DATA;
      end
      DATA: begin
        s_ready = 1'b1;
        tx_en = 1'b1;
        tx_er = !s_valid || s_err;
        txd = s_valid ? s_data : 8'h00;
        cnt_n = '0;
        if (!s_valid) state_n = IFG;
        else begin
          byte_cnt_n = byte_inc;
          if (s_last) state_n = byte_nxt < 12'(MIN_PAYLOAD) ? PAD : TAIL;
        end
      end
      PAD: begin
        tx_en = 1'b1;
        byte_cnt_n = byte_inc;
        cnt_n = '0;
        if (byte_nxt >= 12'(MIN_PAYLOAD)) state_n = TAIL;
      end
`ifdef TX_FCS_EN
      FCS: begin
        tx_en = 1'b1;
        txd = fcs[{cnt[1:0], 3'b000} +: 8];
        if (cnt == 8'd3) begin
          state_n = IFG;
          cnt_n = '0;
        end
      end
`endif
      IFG: begin
        if (cnt == 8'(IFG_BYTES - 1)) begin
          state_n = s_valid ? PREAMBLE : IDLE;
          cnt_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  assign d1 = {tx_en, txd[RGMII_DATA_W-1:0]};
  assign d2 = {tx_en ^ tx_er, txd[7:RGMII_DATA_W]};
  assign rgmii_if_tx_o.data = pin_q[RGMII_DATA_W-1:0];
  assign rgmii_if_tx_o.ctrl = pin_q[RGMII_DATA_W];
  if (TARGET == "SIM") begin : g_sim
    for (genvar i = 0; i <= RGMII_DATA_W; i++) begin : g_bit
      oddr_sim u_oddr (.clk(clk), .r(~rst_n), .d1(d1[i]), .d2(d2[i]), .q(pin_q[i]));
    end
  end else if (TARGET == "XILINX 7-SERIES") begin : g_x7
    for (genvar i = 0; i <= RGMII_DATA_W; i++) begin : g_bit
`ifdef SYNTHESIS
      ODDR #(.DDR_CLK_EDGE("SAME_EDGE")) u_oddr (
        .Q(pin_q[i]), .C(clk), .CE(1'b1), .D1(d1[i]), .D2(d2[i]), .R(~rst_n), .S(1'b0)
      );
`else
      oddr_sim u_oddr (.clk(clk), .r(~rst_n), .d1(d1[i]), .d2(d2[i]), .q(pin_q[i]));
`endif
    end
  end else begin : g_bad
    $error("rgmii_tx_framer: unsupported TARGET %s", TARGET);
  end
endmodule

// File: tb/tb_rgmii_tx_framer.sv
// tb_rgmii_tx_framer: randomized frames checked against a frame-level reference model rebuilt from the RGMII pins
module tb_rgmii_tx_framer;
  import rgmii_tx_framer_pkg::*;
  localparam int PRE = 7, MINP = 60, IFGB = 12;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_valid = 1'b0, s_last = 1'b0, s_err = 1'b0;
  logic s_ready, busy;
  rgmii_if rgm ();
  rgmii_tx_framer #(.TARGET("SIM"), .PREAMBLE_BYTES(PRE), .MIN_PAYLOAD(MINP), .IFG_BYTES(IFGB)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_err(s_err), .s_ready(s_ready), .busy(busy), .rgmii_if_tx_o(rgm)
  );
  always #4 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic en; logic er; logic busy; logic [7:0] d; int cyc;} rec_t;
  rec_t mon_q[$];
  rec_t mon_r;
  logic [3:0] mon_rd;
  logic mon_rc;
  initial forever begin
    @(posedge clk);
    #2;
    mon_rd = rgm.data;
    mon_rc = rgm.ctrl;
    mon_r.busy = busy;
    mon_r.cyc = cyc;
    #4;
    mon_r.d = {rgm.data, mon_rd};
    mon_r.en = mon_rc;
    mon_r.er = mon_rc ^ rgm.ctrl;
    mon_q.push_back(mon_r);
  end
  int errors = 0, checks = 0, t0 = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [7:0] exp_d[$];
  logic exp_er[$];
  int exp_len[$], exp_gap[$];
  function automatic logic [31:0] ref_fcs(input logic [7:0] m[$]);
    logic [31:0] c, r;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (m[i])
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ m[i][b];
        c = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C11DB7;
      end
    for (int k = 0; k < 32; k++) r[k] = ~c[31-k];
    return r;
  endfunction
  function automatic void model_frame(input logic [7:0] pl[$], input int err_idx, input int stop_at, input int gap);
    int n0;
    logic [7:0] body[$];
    logic [31:0] f;
    n0 = exp_d.size();
    for (int i = 0; i < PRE; i++) begin
      exp_d.push_back(8'h55);
      exp_er.push_back(1'b0);
    end
    exp_d.push_back(8'hD5);
    exp_er.push_back(1'b0);
    if (stop_at >= 0) begin
      for (int i = 0; i < stop_at; i++) begin
        exp_d.push_back(pl[i]);
        exp_er.push_back(i == err_idx);
      end
      exp_d.push_back(8'h00);
      exp_er.push_back(1'b1);
    end else begin
      body = pl;
      while (body.size() < MINP) body.push_back(8'h00);
      foreach (body[i]) begin
        exp_d.push_back(body[i]);
        exp_er.push_back(i == err_idx);
      end
      f = ref_fcs(body);
`ifdef TX_FCS_EN
      for (int k = 0; k < 4; k++) begin
        exp_d.push_back(f[8*k +: 8]);
        exp_er.push_back(1'b0);
      end
`endif
    end
    exp_len.push_back(exp_d.size() - n0);
    exp_gap.push_back(gap);
  endfunction
  task automatic drive(input logic [7:0] pl[$], input int err_idx, input int stop_at);
    int n, w;
    bit acc;
    n = stop_at >= 0 ? stop_at : pl.size();
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data = pl[i];
      s_last = stop_at < 0 && i == n - 1;
      s_err = i == err_idx;
      if (i == 0) t0 = cyc;
      acc = 1'b0;
      w = 0;
      while (!acc && w < 500) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
        w++;
      end
      if (!acc) begin
        chk("handshake_timeout", 0, 1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    s_err = 1'b0;
    if (stop_at >= 0) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_idle();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (busy && w < 3000);
    if (busy) chk("idle_timeout", 1, 0);
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic analyze(input string name, input bit lat);
    int p, base, run, bad, g, bz;
    bit bzrun;
    p = 0;
    base = 0;
    foreach (exp_len[f]) begin
      while (p < mon_q.size() && !mon_q[p].en) p++;
      if (lat && f == 0 && p < mon_q.size()) chk({name, "_latency"}, mon_q[p].cyc - t0, 2);
      run = 0;
      bad = 0;
      while (p < mon_q.size() && mon_q[p].en) begin
        if (run < exp_len[f] && (mon_q[p].d !== exp_d[base+run] || mon_q[p].er !== exp_er[base+run])) bad++;
        run++;
        p++;
      end
      chk({name, "_len"}, run, exp_len[f]);
      chk({name, "_bytes"}, bad, 0);
      base += exp_len[f];
      g = 0;
      bz = 0;
      bzrun = 1'b1;
      while (p < mon_q.size() && !mon_q[p].en) begin
        if (bzrun && mon_q[p].busy) bz++;
        else bzrun = 1'b0;
        g++;
        p++;
      end
      // pins trail the FSM by one ODDR stage, so the first idle pin cycle is already the second IFG state
      if (exp_gap[f] >= 0) chk({name, "_gap"}, g, exp_gap[f]);
      else chk({name, "_ifg_busy"}, bz, IFGB - 1);
    end
    exp_d.delete();
    exp_er.delete();
    exp_len.delete();
    exp_gap.delete();
    mon_q.delete();
  endtask
  function automatic void rand_payload(output logic [7:0] pl[$], input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endfunction
  logic [7:0] pa[$], pb[$];
  int la, lb, ea, eb, sa;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", rgm.ctrl, 0);
    chk("rst_data", rgm.data, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data = 8'hA5;
    repeat (12) @(posedge clk);
    #2;
    chk("pre_rst_ctrl", rgm.ctrl, 1);
    chk("pre_rst_data", rgm.data, 4'h5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", rgm.ctrl, 0);
    chk("mid_rst_data", rgm.data, 0);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_busy", busy, 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("post_rst_ctrl", rgm.ctrl, 0);
    chk("post_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    mon_q.delete();
    pa.delete();
    for (int i = 0; i < 64; i++) pa.push_back(8'(i));
    model_frame(pa, -1, -1, -1);
    drive(pa, -1, -1);
    wait_idle();
    analyze("t2_frame64", 1'b1);
    rand_payload(pa, 10);
    model_frame(pa, -1, -1, -1);
    drive(pa, -1, -1);
    wait_idle();
    analyze("t3_pad10", 1'b0);
    rand_payload(pa, 100);
    model_frame(pa, -1, 20, -1);
    drive(pa, -1, 20);
    wait_idle();
    analyze("t4_underrun", 1'b0);
    rand_payload(pa, 70);
    model_frame(pa, 5, -1, -1);
    drive(pa, 5, -1);
    wait_idle();
    analyze("t5_err", 1'b0);
    rand_payload(pa, 30);
    rand_payload(pb, 61);
    model_frame(pa, -1, -1, IFGB);
    model_frame(pb, -1, -1, -1);
    drive(pa, -1, -1);
    drive(pb, -1, -1);
    wait_idle();
    analyze("t6_b2b", 1'b0);
    for (int r = 0; r < 6; r++) begin
      la = $urandom_range(1, 90);
      lb = $urandom_range(1, 90);
      ea = $urandom_range(0, 2) == 0 ? $urandom_range(0, la - 1) : -1;
      eb = $urandom_range(0, 2) == 0 ? $urandom_range(0, lb - 1) : -1;
      sa = (la > 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, la - 1) : -1;
      rand_payload(pa, la);
      rand_payload(pb, lb);
      model_frame(pa, ea, sa, IFGB);
      model_frame(pb, eb, -1, -1);
      drive(pa, ea, sa);
      drive(pb, eb, -1);
      wait_idle();
      analyze($sformatf("rand%0d", r), 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
